// File: rtl/id_issue_queue_pkg.sv
// rtl/id_issue_queue_pkg.sv - opcode groups, register-index width and head decode helpers
package id_issue_queue_pkg;

  localparam int NREGS_ARCH = 32;
  localparam int REG_W = $clog2(NREGS_ARCH);

  typedef enum logic [6:0] {
    OP_R       = 7'b0110011,
    OP_I_ARITH = 7'b0010011,
    OP_I_LD    = 7'b0000011,
    OP_I_JAL   = 7'b1100111,
    OP_S       = 7'b0100011,
    OP_B       = 7'b1100011,
    OP_U_LD    = 7'b0110111,
    OP_U_AUIPC = 7'b0010111,
    OP_J       = 7'b1101111
  } opcode_e;

  typedef struct packed {
    logic             rs1_used;
    logic             rs2_used;
    logic             reg_wr;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } head_dec_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_R, OP_S, OP_B, OP_I_ARITH, OP_I_LD, OP_I_JAL: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_S, OP_B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_I_ARITH, OP_I_LD, OP_I_JAL, OP_U_LD, OP_U_AUIPC, OP_J: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // x0 is hardwired, so it never creates a dependency or a pending write
  function automatic head_dec_t decode_inst(input logic [31:0] inst);
    head_dec_t d;
    d.rd       = inst[11:7];
    d.rs1      = inst[19:15];
    d.rs2      = inst[24:20];
    d.rs1_used = uses_rs1(inst[6:0]) && (d.rs1 != '0);
    d.rs2_used = uses_rs2(inst[6:0]) && (d.rs2 != '0);
    d.reg_wr   = writes_rd(inst[6:0]) && (d.rd != '0);
    return d;
  endfunction

endpackage

// File: rtl/id_issue_queue_if.sv
// rtl/id_issue_queue_if.sv - IF/EX/WB handshake bundle of the issue queue
interface id_issue_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  import id_issue_queue_pkg::*;

  logic                   if_valid;
  logic                   if_ready;
  logic [31:0]            if_inst;
  logic [XLEN-1:0]        if_pc;
  logic                   flush;
  logic                   iss_valid;
  logic                   iss_ready;
  logic [31:0]            iss_inst;
  logic [XLEN-1:0]        iss_pc;
  logic [REG_W-1:0]       iss_rd_idx;
  logic                   iss_reg_wr;
  logic                   wb_valid;
  logic [REG_W-1:0]       wb_rd_idx;
  logic                   hazard_stall;
  logic [$clog2(DEPTH):0] occupancy;

  modport slave (
    input  if_valid, if_inst, if_pc, flush, iss_ready, wb_valid, wb_rd_idx,
    output if_ready, iss_valid, iss_inst, iss_pc, iss_rd_idx, iss_reg_wr, hazard_stall, occupancy
  );

  modport master (
    output if_valid, if_inst, if_pc, flush, iss_ready, wb_valid, wb_rd_idx,
    input  if_ready, iss_valid, iss_inst, iss_pc, iss_rd_idx, iss_reg_wr, hazard_stall, occupancy
  );

endinterface

// File: rtl/id_issue_queue_scoreboard.sv
// rtl/id_issue_queue_scoreboard.sv - per-register counting scoreboard of in-flight writes
module id_scoreboard
  import id_issue_queue_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en,
  input  logic [REG_W-1:0] inc_idx,
  input  logic             dec_en,
  input  logic [REG_W-1:0] dec_idx,
  input  logic [REG_W-1:0] q1_idx,
  input  logic [REG_W-1:0] q2_idx,
  input  logic [REG_W-1:0] sat_idx,
  output logic             busy1,
  output logic             busy2,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];

  // Entry 0 is skipped so it stays zero; a release at zero is dropped, and an
  // issue plus a release on the same register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 1; i < NREGS; i++) begin
      if (inc_en && inc_idx == REG_W'(i) && cnt_q[i] != CNT_MAX) begin
        if (!(dec_en && dec_idx == REG_W'(i) && cnt_q[i] != '0))
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_en && dec_idx == REG_W'(i) && cnt_q[i] != '0) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    busy1 = cnt_q[q1_idx] != '0;
    busy2 = cnt_q[q2_idx] != '0;
    sat   = cnt_q[sat_idx] == CNT_MAX;
  end

endmodule

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - buffered decode/issue queue with scoreboard interlock between IF and EX
module id_issue_queue
  import id_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  id_issue_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];
  logic [XLEN-1:0]  pc_mem_q   [DEPTH];
  logic [XLEN-1:0]  pc_mem_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  head_dec_t hd;
  logic busy_rs1, busy_rs2, rd_sat;
  logic blocked, not_empty, full, enq, deq;

  assign hd = decode_inst(inst_mem_q[head_q]);

  id_scoreboard #(.NREGS(NREGS), .CNT_W(CNT_W)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (deq & hd.reg_wr),
    .inc_idx (hd.rd),
    .dec_en  (bus.wb_valid),
    .dec_idx (bus.wb_rd_idx),
    .q1_idx  (hd.rs1),
    .q2_idx  (hd.rs2),
    .sat_idx (hd.rd),
    .busy1   (busy_rs1),
    .busy2   (busy_rs2),
    .sat     (rd_sat)
  );

  // A saturated counter on rd blocks too: one more issue would overflow it
  always_comb begin
    not_empty        = count_q != '0;
    full             = count_q == FULL_CNT;
    blocked          = (hd.rs1_used & busy_rs1) | (hd.rs2_used & busy_rs2) | (hd.reg_wr & rd_sat);
    bus.if_ready     = ~full;
    bus.iss_valid    = not_empty & ~blocked & ~bus.flush;
    bus.hazard_stall = not_empty & blocked;
    bus.iss_inst     = inst_mem_q[head_q];
    bus.iss_pc       = pc_mem_q[head_q];
    bus.iss_rd_idx   = hd.reg_wr ? hd.rd : '0;
    bus.iss_reg_wr   = hd.reg_wr;
    bus.occupancy    = count_q;
    enq              = bus.if_valid & ~full & ~bus.flush;
    deq              = not_empty & ~blocked & ~bus.flush & bus.iss_ready;
  end

  always_comb begin
    inst_mem_d = inst_mem_q;
    pc_mem_d   = pc_mem_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (bus.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        inst_mem_d[tail_q] = bus.if_inst;
        pc_mem_d[tail_q]   = bus.if_pc;
        tail_d             = tail_q + PTR_W'(1);
      end
      if (deq) head_d = head_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; it is only meaningful behind count_q
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// tb/tb_id_issue_queue.sv - directed vector table plus randomized reference-model run for id_issue_queue
module tb_id_issue_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int SAT   = (1 << 2) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_issue_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  id_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NREGS(32), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          rst;
    bit          ifv;
    logic [31:0] inst;
    bit          fl;
    bit          irdy;
    bit          wbv;
    logic [4:0]  wbrd;
    bit          chk;
    bit          e_iv;
    bit          e_st;
    int          e_occ;
    bit          e_ifr;
    int          e_rd;
  } vec_t;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } ent_t;

  vec_t            vecs[$];
  ent_t            mq[$];
  int              pend[32];
  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] pc_ctr = 32'h1000;
  logic [6:0]      ops[10] = '{7'h33, 7'h23, 7'h63, 7'h13, 7'h03, 7'h67, 7'h37, 7'h17, 7'h6F, 7'h7F};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_add(input int rd, input int rs1, input int rs2);
    return {7'b0000000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_sub(input int rd, input int rs1, input int rs2);
    return {7'b0100000, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
    return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
  endfunction
  function automatic logic [31:0] enc_lui(input int rd, input int imm);
    return {20'(imm), 5'(rd), 7'h37};
  endfunction

  function automatic void v(input bit ifv, input logic [31:0] inst, input bit fl, input bit irdy,
                            input bit wbv, input int wbrd, input bit e_iv, input bit e_st,
                            input int e_occ, input bit e_ifr, input int e_rd);
    vec_t r;
    r.rst = 1'b0; r.ifv = ifv; r.inst = inst; r.fl = fl; r.irdy = irdy; r.wbv = wbv;
    r.wbrd = 5'(wbrd); r.chk = 1'b1; r.e_iv = e_iv; r.e_st = e_st; r.e_occ = e_occ;
    r.e_ifr = e_ifr; r.e_rd = e_rd;
    vecs.push_back(r);
  endfunction

  function automatic void vr();
    vec_t r;
    r.rst = 1'b1; r.ifv = 1'b0; r.inst = '0; r.fl = 1'b0; r.irdy = 1'b0; r.wbv = 1'b0;
    r.wbrd = '0; r.chk = 1'b0; r.e_iv = 1'b0; r.e_st = 1'b0; r.e_occ = 0; r.e_ifr = 1'b0; r.e_rd = -1;
    vecs.push_back(r);
  endfunction

  task automatic drive(input bit r, input bit ifv, input logic [31:0] inst, input bit fl,
                       input bit irdy, input bit wbv, input logic [4:0] wbrd);
    rst           = r;
    bus.if_valid  = ifv;
    bus.if_inst   = inst;
    bus.if_pc     = pc_ctr;
    bus.flush     = fl;
    bus.iss_ready = irdy;
    bus.wb_valid  = wbv;
    bus.wb_rd_idx = wbrd;
  endtask

  // Operand/write usage by opcode group; x0 never counts
  function automatic void ref_dec(input logic [31:0] inst, output bit u1, output bit u2, output bit w);
    u1 = 1'b0; u2 = 1'b0; w = 1'b0;
    case (inst[6:0])
      7'h33:               begin u1 = 1'b1; u2 = 1'b1; w = 1'b1; end
      7'h23, 7'h63:        begin u1 = 1'b1; u2 = 1'b1; end
      7'h13, 7'h03, 7'h67: begin u1 = 1'b1; w = 1'b1; end
      7'h37, 7'h17, 7'h6F: w = 1'b1;
      default: ;
    endcase
    if (inst[19:15] == 5'd0) u1 = 1'b0;
    if (inst[24:20] == 5'd0) u2 = 1'b0;
    if (inst[11:7] == 5'd0) w = 1'b0;
  endfunction

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;

    // reset state and fill to DEPTH with EX stalled
    vr();
    v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_addi(10, 0, 1), 0, 0, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_addi(11, 0, 1), 0, 0, 0, 0, 1, 0, 1, 1, 10);
    v(1, enc_addi(12, 0, 1), 0, 0, 0, 0, 1, 0, 2, 1, 10);
    v(1, enc_addi(13, 0, 1), 0, 0, 0, 0, 1, 0, 3, 1, 10);
    v(1, enc_addi(14, 0, 1), 0, 0, 0, 0, 1, 0, 4, 0, 10);
    v(1, enc_addi(14, 0, 1), 0, 0, 0, 0, 1, 0, 4, 0, 10);
    v(1, enc_addi(14, 0, 1), 0, 1, 0, 0, 1, 0, 4, 0, 10);
    v(0, 0, 0, 1, 0, 0, 1, 0, 3, 1, 11);
    v(0, 0, 0, 1, 0, 0, 1, 0, 2, 1, 12);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 13);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    vr();
    // RAW on x5, released by WB with one cycle of scoreboard latency
    v(1, enc_add(5, 1, 2), 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_sub(6, 5, 3), 0, 1, 0, 0, 1, 0, 1, 1, 5);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 6);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 6);
    v(0, 0, 0, 1, 1, 5, 0, 1, 1, 1, 6);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 6);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    // x0 destination and no-source instructions issue back-to-back
    v(1, enc_addi(0, 0, 1), 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_lui(7, 'h12345), 0, 1, 0, 0, 1, 0, 1, 1, 0);
    v(1, enc_add(8, 0, 0), 0, 1, 0, 0, 1, 0, 1, 1, 7);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 8);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    // counter saturation on x9
    v(1, enc_addi(9, 0, 1), 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_addi(9, 0, 2), 0, 1, 0, 0, 1, 0, 1, 1, 9);
    v(1, enc_addi(9, 0, 3), 0, 1, 0, 0, 1, 0, 1, 1, 9);
    v(1, enc_addi(9, 0, 4), 0, 1, 0, 0, 1, 0, 1, 1, 9);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 9);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 9);
    v(0, 0, 0, 1, 1, 9, 0, 1, 1, 1, 9);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 9);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    // flush at occupancy 3 drops the queue and the concurrent enqueue, not the counters
    v(1, enc_addi(20, 0, 0), 0, 0, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_addi(21, 0, 0), 0, 0, 0, 0, 1, 0, 1, 1, 20);
    v(1, enc_addi(22, 0, 0), 0, 0, 0, 0, 1, 0, 2, 1, 20);
    v(1, enc_addi(23, 0, 0), 1, 1, 0, 0, 0, 0, 3, 1, 20);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_addi(9, 0, 5), 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 9);
    v(0, 0, 0, 1, 1, 9, 0, 1, 1, 1, 9);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 9);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(1, enc_add(1, 6, 0), 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1);
    v(0, 0, 0, 1, 1, 6, 0, 1, 1, 1, 1);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);
    // 10-instruction stream with pointer wrap; x4 issue and WB coincide
    for (int i = 0; i < 10; i++) begin
      int rdi  = (i == 0 || i == 5) ? 4 : 16 + i;
      int prev = (i == 1 || i == 6) ? 4 : 15 + i;
      v(1, enc_addi(rdi, 0, i), 0, 1, (i == 6), 4, (i > 0), 0, (i > 0) ? 1 : 0, 1, (i > 0) ? prev : -1);
    end
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 25);
    v(1, enc_add(2, 4, 0), 0, 1, 0, 0, 0, 0, 0, 1, -1);
    v(0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 2);
    v(0, 0, 0, 1, 1, 4, 0, 1, 1, 1, 2);
    v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 2);
    v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, -1);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t r = vecs[i];
      drive(r.rst, r.ifv, r.inst, r.fl, r.irdy, r.wbv, r.wbrd);
      @(negedge clk);
      if (r.chk) begin
        chk($sformatf("v%0d iss_valid", i), 64'(bus.iss_valid), 64'(r.e_iv));
        chk($sformatf("v%0d hazard_stall", i), 64'(bus.hazard_stall), 64'(r.e_st));
        chk($sformatf("v%0d occupancy", i), 64'(bus.occupancy), 64'(r.e_occ));
        chk($sformatf("v%0d if_ready", i), 64'(bus.if_ready), 64'(r.e_ifr));
        if (r.e_rd >= 0) begin
          chk($sformatf("v%0d iss_rd_idx", i), 64'(bus.iss_rd_idx), 64'(r.e_rd));
          chk($sformatf("v%0d iss_reg_wr", i), 64'(bus.iss_reg_wr), 64'(r.e_rd != 0));
        end
      end
      @(posedge clk); #1;
      if (r.ifv) pc_ctr += 4;
    end

    // randomized traffic against the queue/counter reference model
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    mq.delete();
    foreach (pend[k]) pend[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      bit ifv, fl, irdy, wbv, u1, u2, w, blk, e_iv, e_ifr, take, put;
      logic [31:0] inst;
      logic [4:0]  wbrd;
      int rd, rs1, rs2, occ;
      ifv  = ($urandom % 100) < 60;
      fl   = ($urandom % 100) < 4;
      irdy = ($urandom % 100) < 70;
      wbv  = ($urandom % 100) < 35;
      wbrd = 5'($urandom % 8);
      inst = $urandom;
      inst[6:0]   = ops[$urandom % 10];
      inst[11:7]  = 5'($urandom % 8);
      inst[19:15] = 5'($urandom % 8);
      inst[24:20] = 5'($urandom % 8);
      drive(1'b0, ifv, inst, fl, irdy, wbv, wbrd);

      occ = mq.size();
      e_ifr = occ != DEPTH;
      e_iv = 1'b0; blk = 1'b0; w = 1'b0; rd = 0;
      if (occ > 0) begin
        ref_dec(mq[0].inst, u1, u2, w);
        rd  = int'(mq[0].inst[11:7]);
        rs1 = int'(mq[0].inst[19:15]);
        rs2 = int'(mq[0].inst[24:20]);
        blk = (u1 && pend[rs1] != 0) || (u2 && pend[rs2] != 0) || (w && pend[rd] == SAT);
        e_iv = !blk && !fl;
      end

      @(negedge clk);
      chk($sformatf("r%0d iss_valid", c), 64'(bus.iss_valid), 64'(e_iv));
      chk($sformatf("r%0d hazard_stall", c), 64'(bus.hazard_stall), 64'(occ > 0 && blk));
      chk($sformatf("r%0d occupancy", c), 64'(bus.occupancy), 64'(occ));
      chk($sformatf("r%0d if_ready", c), 64'(bus.if_ready), 64'(e_ifr));
      if (occ > 0) begin
        chk($sformatf("r%0d iss_inst", c), 64'(bus.iss_inst), 64'(mq[0].inst));
        chk($sformatf("r%0d iss_pc", c), 64'(bus.iss_pc), 64'(mq[0].pc));
        chk($sformatf("r%0d iss_rd_idx", c), 64'(bus.iss_rd_idx), 64'(w ? rd : 0));
        chk($sformatf("r%0d iss_reg_wr", c), 64'(bus.iss_reg_wr), 64'(w));
      end
      @(posedge clk); #1;

      take = e_iv && irdy;
      put  = ifv && e_ifr && !fl;
      if (wbv && wbrd != 5'd0 && pend[wbrd] > 0) pend[wbrd]--;
      if (take && w) pend[rd]++;
      if (fl) mq.delete();
      else begin
        if (take) void'(mq.pop_front());
        if (put) mq.push_back('{inst, pc_ctr});
      end
      if (ifv) pc_ctr += 4;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
Name: id_issue_queue

Overview:
- Parametrised successor to the in-order decode stage.
- Buffers fetched instructions in a DEPTH-entry circular queue between IF and EX.
- Tracks in-flight register writes with a per-register counting scoreboard.
- Issues the head instruction to EX only when it has no RAW or WAW conflict; replaces the single-cycle, index-compare hazard flag with a buffered, handshaked interlock.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- XLEN, 32, PC width.
- NREGS, 32, architectural registers; index width is $clog2(NREGS)=5.
- CNT_W, 2, width of each per-register pending-write counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- if_valid  in  1  IF presents an instruction
- if_ready  out  1  queue can accept
- if_inst  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- flush  in  1  discard all queued instructions (branch redirect)
- iss_valid  out  1  head entry issuable this cycle
- iss_ready  in  1  EX accepts
- iss_inst  out  32  head instruction
- iss_pc  out  XLEN  head PC
- iss_rd_idx  out  5  head destination; 0 when the instruction does not write rd
- iss_reg_wr  out  1  head writes rd
- wb_valid  in  1  a register write retires
- wb_rd_idx  in  5  retiring destination
- hazard_stall  out  1  queue non-empty but head blocked by the scoreboard
- occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset clears head, tail, count and every scoreboard counter. After reset: if_ready=1, iss_valid=0, hazard_stall=0, occupancy=0.
- Enqueue:
  - Occurs when if_valid & if_ready & ~flush; writes {inst, pc} at tail; tail wraps DEPTH-1→0.
  - if_ready = (count != DEPTH). If full, no enqueue even when a dequeue happens the same cycle.
  - No bypass: an instruction enqueued into an empty queue is first visible on iss_* the next cycle (latency 1).
- Head decode:
  - Combinational from head entry: rs1_used, rs2_used, reg_wr, using the opcode groups of sys_defs.vh.
  - R/S/B groups use rs1 and rs2. I_ARITH, I_LD and I_JAL groups use rs1. U_LD, U_AUIPC and J groups use neither.
  - Index 0 never counts as used or written.
- Hazard:
  - Blocked when any of: (rs1_used & pend[rs1]≠0); (rs2_used & pend[rs2]≠0); (reg_wr & pend[rd]==2^CNT_W−1, counter saturated).
  - iss_valid = (count≠0) & ~blocked & ~flush.
  - hazard_stall = (count≠0) & blocked.
- Dequeue:
  - Occurs when iss_valid & iss_ready; head advances with wrap.
  - If reg_wr and rd≠0, pend[rd] increments.
  - Simultaneous enqueue and dequeue with 0<count<DEPTH leaves count unchanged.
- Release:
  - wb_valid & wb_rd_idx≠0 decrements pend[wb_rd_idx]; a decrement at 0 is ignored.
  - Issue increment and release decrement on the same register in the same cycle leave its counter unchanged.
  - Scoreboard is registered: a release unblocks the head no earlier than the next cycle (no same-cycle WB bypass).
- Flush:
  - Synchronous: next cycle head=tail=count=0.
  - In the flush cycle iss_valid=0 and the enqueue is dropped.
  - The scoreboard is NOT cleared, because already-issued instructions still write back.
- Reset asserted mid-operation overrides flush, enqueue and release in that cycle.
- iss_* fields are driven from head storage even when iss_valid=0; the consumer qualifies them with iss_valid.

Decomposition:
- Shared package: uses_rs1/uses_rs2/writes_rd functions keyed on the sys_defs.vh opcodes, and the reg-index width constant.
- Sub-module id_scoreboard (params NREGS, CNT_W):
  - Inputs: inc_en, inc_idx, dec_en, dec_idx, and two query indices plus one saturation query index.
  - Outputs: busy flags and a saturated flag.
- The queue, pointers and handshake stay in the top module.

Test Plan:
- Fill: rst, then 4 back-to-back enqueues with iss_ready=0 → occupancy=4, if_ready=0 the cycle after the 4th; a 5th if_valid is not accepted.
- RAW: issue "add x5,x1,x2" then queue "sub x6,x5,x3" → hazard_stall=1, iss_valid=0. Assert wb_valid with wb_rd_idx=5 → iss_valid=1 exactly one cycle later.
- x0 and no-source: "addi x0,x0,1" followed by "lui x7,0x12345" → both issue back-to-back with no stall; pend[0] stays 0.
- Saturation (CNT_W=2): three issued writes to x9 with no WB; the fourth write to x9 → hazard_stall=1 until one WB to x9 is seen.
- Flush: with occupancy=3 and if_valid=1, assert flush one cycle → next cycle occupancy=0 and the flushed enqueue is lost; pending counters are unchanged.
- Wrap and concurrency: 10 instructions streamed with iss_ready=1 and no dependencies → one issue per cycle after the first; pointers wrap correctly; same-cycle issue and WB on x4 leaves pend[4] unchanged.
